// File: rtl/mux_pkg.sv
// Shared constants for the scan mux slice.
// Mode encodings used by the select logic.
package mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/onehot_dec.sv
// Combinational binary to one-hot decoder.
// Output bit k is high iff s == k.
module onehot_dec
  import mux_pkg::*;
#(
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0]      s,
  output logic [(2**SEL_W)-1:0] y
);

  // Set exactly the bit addressed by s.
  always_comb begin
    y    = '0;
    y[s] = 1'b1;
  end

endmodule

// File: rtl/scan_mux_seq.sv
// N:1 channel selector with manual/scan select,
// registered output stage and valid/ready output.
module scan_mux_seq
  import mux_pkg::*;
#(
  parameter int SEL_W  = 3,
  parameter int DATA_W = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          mode,
  input  logic [SEL_W-1:0]              sel_in,
  input  logic                          sel_load,
  input  logic                          en,
  input  logic [(2**SEL_W)*DATA_W-1:0]  data_in,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [DATA_W-1:0]             out_data,
  output logic [SEL_W-1:0]              out_sel,
  output logic [(2**SEL_W)-1:0]         onehot,
  output logic                          wrap
);

  localparam int N = 2**SEL_W;

  logic [SEL_W-1:0]  sel_q;
  logic [N-1:0]      dec;
  logic [DATA_W-1:0] word;
  logic              cap;
  logic              scan;
  logic              at_last;

  // A new word may enter when the stage is empty or draining.
  assign cap     = en & (~out_valid | out_ready);
  assign scan    = (mode == MODE_SCAN);
  assign at_last = &sel_q;
  assign word    = data_in[sel_q*DATA_W +: DATA_W];

  onehot_dec #(.SEL_W(SEL_W)) u_dec (
    .s (sel_q),
    .y (dec)
  );

  // Select register: explicit load beats scan advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q <= '0;
    end else if (sel_load) begin
      sel_q <= sel_in;
    end else if (scan && cap) begin
      sel_q <= sel_q + 1'b1;
    end
  end

  // Output stage: capture, drain, or hold under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      onehot    <= '0;
    end else if (cap) begin
      out_valid <= 1'b1;
      out_data  <= word;
      out_sel   <= sel_q;
      onehot    <= dec;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      onehot    <= '0;
    end
  end

  // Wrap pulse when a scan capture rolls the pointer past N-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrap <= 1'b0;
    end else begin
      wrap <= scan & cap & ~sel_load & at_last;
    end
  end

endmodule

// File: tb/tb_scan_mux_seq.sv
// Directed bench for scan_mux_seq.
// Vector table plus a hand-written backpressure sequence.
module tb_scan_mux_seq;

  localparam int SEL_W  = 3;
  localparam int DATA_W = 8;
  localparam int N      = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              mode;
  logic [SEL_W-1:0]  sel_in;
  logic              sel_load;
  logic              en;
  logic [N*DATA_W-1:0] data_in;
  logic              out_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [SEL_W-1:0]  out_sel;
  logic [N-1:0]      onehot;
  logic              wrap;

  int checks = 0;
  int passes = 0;

  typedef struct {
    string      tag;
    logic       rst;
    logic       mode;
    logic       ld;
    logic [2:0] sin;
    logic       en;
    logic       rdy;
    logic [7:0] base;
    logic       ev;
    logic [7:0] ed;
    logic [2:0] es;
    logic [7:0] eoh;
    logic       ew;
  } vec_t;

  vec_t tbl[$];

  scan_mux_seq #(.SEL_W(SEL_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel_in    (sel_in),
    .sel_load  (sel_load),
    .en        (en),
    .data_in   (data_in),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .onehot    (onehot),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  task automatic set_data(input logic [7:0] base);
    for (int k = 0; k < N; k++)
      data_in[k*DATA_W +: DATA_W] = base + 8'(k);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_all(input string tag, input logic ev,
                         input logic [7:0] ed, input logic [2:0] es,
                         input logic [7:0] eoh, input logic ew);
    chk({tag, ".valid"},  int'(out_valid), int'(ev));
    chk({tag, ".data"},   int'(out_data),  int'(ed));
    chk({tag, ".sel"},    int'(out_sel),   int'(es));
    chk({tag, ".onehot"}, int'(onehot),    int'(eoh));
    chk({tag, ".wrap"},   int'(wrap),      int'(ew));
  endtask

  task automatic add(input string tag, input logic r, input logic m,
                     input logic ld, input logic [2:0] sin,
                     input logic e, input logic rdy, input logic [7:0] base,
                     input logic ev, input logic [7:0] ed,
                     input logic [2:0] es, input logic [7:0] eoh,
                     input logic ew);
    vec_t v;
    v.tag = tag; v.rst = r; v.mode = m; v.ld = ld; v.sin = sin;
    v.en = e; v.rdy = rdy; v.base = base;
    v.ev = ev; v.ed = ed; v.es = es; v.eoh = eoh; v.ew = ew;
    tbl.push_back(v);
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      rst       = tbl[i].rst;
      mode      = tbl[i].mode;
      sel_load  = tbl[i].ld;
      sel_in    = tbl[i].sin;
      en        = tbl[i].en;
      out_ready = tbl[i].rdy;
      set_data(tbl[i].base);
      @(posedge clk);
      #1;
      chk_all(tbl[i].tag, tbl[i].ev, tbl[i].ed, tbl[i].es,
              tbl[i].eoh, tbl[i].ew);
    end
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; sel_in = '0; sel_load = 1'b0;
    en = 1'b0; out_ready = 1'b0; data_in = '0;

    // rows 0..15: reset, manual, scan sweep
    add("rst0",  1,0,0,0,0,0,8'hA0, 0,8'h00,0,8'h00,0);
    add("ld5",   0,0,1,5,0,1,8'hA0, 0,8'h00,0,8'h00,0);
    add("man1",  0,0,0,0,1,1,8'hA0, 1,8'hA5,5,8'h20,0);
    add("man2",  0,0,0,0,1,1,8'hA0, 1,8'hA5,5,8'h20,0);
    add("drn0",  0,0,0,0,0,1,8'hA0, 0,8'hA5,5,8'h00,0);
    add("ld0",   0,1,1,0,0,1,8'hA0, 0,8'hA5,5,8'h00,0);
    add("scan0", 0,1,0,0,1,1,8'hA0, 1,8'hA0,0,8'h01,0);
    add("scan1", 0,1,0,0,1,1,8'hA0, 1,8'hA1,1,8'h02,0);
    add("scan2", 0,1,0,0,1,1,8'hA0, 1,8'hA2,2,8'h04,0);
    add("scan3", 0,1,0,0,1,1,8'hA0, 1,8'hA3,3,8'h08,0);
    add("scan4", 0,1,0,0,1,1,8'hA0, 1,8'hA4,4,8'h10,0);
    add("scan5", 0,1,0,0,1,1,8'hA0, 1,8'hA5,5,8'h20,0);
    add("scan6", 0,1,0,0,1,1,8'hA0, 1,8'hA6,6,8'h40,0);
    add("scan7", 0,1,0,0,1,1,8'hA0, 1,8'hA7,7,8'h80,1);
    add("scan8", 0,1,0,0,1,1,8'hA0, 1,8'hA0,0,8'h01,0);
    add("scan9", 0,1,0,0,1,1,8'hA0, 1,8'hA1,1,8'h02,0);
    // rows 16..24: drain, load collision, mode freeze, reset
    add("drn1",  0,1,0,0,0,1,8'hA0, 0,8'hE2,2,8'h00,0);
    add("aftdr", 0,1,0,0,1,1,8'hA0, 1,8'hA3,3,8'h08,0);
    add("ld7",   0,1,1,7,0,1,8'hA0, 0,8'hA3,3,8'h00,0);
    add("coll",  0,1,1,2,1,1,8'hA0, 1,8'hA7,7,8'h80,0);
    add("post",  0,1,0,0,1,1,8'hA0, 1,8'hA2,2,8'h04,0);
    add("frz1",  0,0,0,0,1,1,8'hA0, 1,8'hA3,3,8'h08,0);
    add("frz2",  0,0,0,0,1,1,8'hA0, 1,8'hA3,3,8'h08,0);
    add("rst1",  1,1,0,0,1,1,8'hA0, 0,8'h00,0,8'h00,0);
    add("rcap",  0,1,0,0,1,1,8'hA0, 1,8'hA0,0,8'h01,0);

    run_rows(0, 15);

    // Backpressure: outputs frozen while data_in changes.
    rst = 0; mode = 1; sel_load = 0; en = 1; out_ready = 0;
    for (int c = 0; c < 3; c++) begin
      set_data(8'hB0 + 8'(c * 16));
      @(posedge clk);
      #1;
      chk_all($sformatf("hold%0d", c), 1, 8'hA1, 1, 8'h02, 0);
    end
    out_ready = 1;
    set_data(8'hE0);
    @(posedge clk);
    #1;
    chk_all("release", 1, 8'hE2, 2, 8'h04, 0);

    run_rows(16, 24);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
